// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch allocator.
//   alloc_state_t : per-output allocation state (IDLE / BUSY)
//   sel_width(n)  : index width for n ports, at least one bit even when n == 1
package switch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return $clog2(n) + ((n == 1) ? 1 : 0);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request / crossbar-control bundle between the input ports, the allocator and the crossbar.
//   req_valid   : input i has a packet at its head
//   req_dest    : destination output of input i's head packet
//   packet_sent : crossbar finished the packet on output o (1-cycle pulse)
//   sel, enable : crossbar select / enable per output
//   in_granted  : input i currently owns an output
//   timeout_err : forced-release pulse per output
// Modports: master = request/crossbar side, slave = allocator.
interface switch_allocator_if
  import switch_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_OUT = 4
);
  localparam int unsigned SELECT_SIZE = sel_width(NUM_IN);
  localparam int unsigned OUT_SIZE    = sel_width(NUM_OUT);

  logic [NUM_IN-1:0]                   req_valid;
  logic [NUM_IN-1:0][OUT_SIZE-1:0]     req_dest;
  logic [NUM_OUT-1:0]                  packet_sent;
  logic [NUM_OUT-1:0][SELECT_SIZE-1:0] sel;
  logic [NUM_OUT-1:0]                  enable;
  logic [NUM_IN-1:0]                   in_granted;
  logic [NUM_OUT-1:0]                  timeout_err;

  modport master (
    output req_valid, req_dest, packet_sent,
    input  sel, enable, in_granted, timeout_err
  );

  modport slave (
    input  req_valid, req_dest, packet_sent,
    output sel, enable, in_granted, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
//   req         : request vector
//   ptr         : highest-priority index
//   grant_valid : at least one request present
//   grant_idx   : index of the winner (0 when none)
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = sel_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  int unsigned idx;

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-output allocator for the switch crossbar. Each output runs its own
// IDLE/BUSY FSM with a round-robin arbiter over eligible inputs, holds the
// grant until packet_sent, and then releases it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : switch_allocator_if.slave (requests in, crossbar control out)
// Optional feature: define SWITCH_ALLOC_TIMEOUT_EN to force release of an
// output that stays BUSY for TIMEOUT cycles, pulsing timeout_err.
module switch_allocator
  import switch_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  switch_allocator_if.slave   bus
);

  localparam int unsigned SELECT_SIZE = sel_width(NUM_IN);
  localparam int unsigned OUT_SIZE    = sel_width(NUM_OUT);

  alloc_state_t state_q [NUM_OUT];
  alloc_state_t state_d [NUM_OUT];

  logic [NUM_OUT-1:0][SELECT_SIZE-1:0] sel_q, sel_d;
  logic [NUM_OUT-1:0][SELECT_SIZE-1:0] ptr_q, ptr_d;
  logic [NUM_OUT-1:0]                  enable_q, enable_d;
  logic [NUM_IN-1:0]                   in_granted_q, in_granted_d;

  logic [NUM_OUT-1:0][NUM_IN-1:0]      elig_c;
  logic [NUM_OUT-1:0]                  grant_valid_c;
  logic [NUM_OUT-1:0][SELECT_SIZE-1:0] grant_idx_c;
  logic [NUM_OUT-1:0]                  timeout_c;
  logic [NUM_OUT-1:0]                  release_c;

  // Eligible: valid, addressed to this output, and not already holding a grant.
  // Out-of-range destinations match no output and are dropped naturally.
  always_comb begin
    elig_c = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      for (int i = 0; i < int'(NUM_IN); i++) begin
        elig_c[o][i] = bus.req_valid[i] && (bus.req_dest[i] == OUT_SIZE'(o)) && !in_granted_q[i];
      end
    end
  end

  for (genvar o = 0; o < int'(NUM_OUT); o++) begin : g_arb
    rr_arbiter #(
      .N (NUM_IN),
      .W (SELECT_SIZE)
    ) u_arb (
      .req         (elig_c[o]),
      .ptr         (ptr_q[o]),
      .grant_valid (grant_valid_c[o]),
      .grant_idx   (grant_idx_c[o])
    );
  end

`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [NUM_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_OUT-1:0]            timeout_err_q, timeout_err_d;

  // Counter holds the number of BUSY cycles already completed; the current
  // cycle is the TIMEOUT-th when it reads TIMEOUT-1. packet_sent wins.
  always_comb begin
    timeout_c     = '0;
    cnt_d         = cnt_q;
    timeout_err_d = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      timeout_c[o] = (state_q[o] == BUSY) && !bus.packet_sent[o] &&
                     (cnt_q[o] == CNT_W'(TIMEOUT - 1));
      if (state_q[o] != BUSY || bus.packet_sent[o] || timeout_c[o]) begin
        cnt_d[o] = '0;
      end else begin
        cnt_d[o] = cnt_q[o] + CNT_W'(1);
      end
      timeout_err_d[o] = timeout_c[o];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      timeout_err_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_c       = '0;
  assign bus.timeout_err = '0;
`endif

  always_comb begin
    release_c = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      release_c[o] = (state_q[o] == BUSY) && (bus.packet_sent[o] || timeout_c[o]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '{default: IDLE};
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      case (state_q[o])
        IDLE:    if (grant_valid_c[o]) state_d[o] = BUSY;
        BUSY:    if (release_c[o])     state_d[o] = IDLE;
        default: state_d[o] = IDLE;
      endcase
    end
  end

  // Output / datapath next values. sel keeps its last value on release.
  always_comb begin
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    enable_d     = enable_q;
    in_granted_d = in_granted_q;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      if (state_q[o] == IDLE && grant_valid_c[o]) begin
        sel_d[o]    = grant_idx_c[o];
        enable_d[o] = 1'b1;
        ptr_d[o]    = (grant_idx_c[o] == SELECT_SIZE'(NUM_IN - 1)) ?
                      '0 : grant_idx_c[o] + SELECT_SIZE'(1);
        for (int i = 0; i < int'(NUM_IN); i++) begin
          if (grant_idx_c[o] == SELECT_SIZE'(i)) in_granted_d[i] = 1'b1;
        end
      end else if (release_c[o]) begin
        enable_d[o] = 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
          if (sel_q[o] == SELECT_SIZE'(i)) in_granted_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= '0;
      ptr_q        <= '0;
      enable_q     <= '0;
      in_granted_q <= '0;
    end else begin
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      enable_q     <= enable_d;
      in_granted_q <= in_granted_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.enable     = enable_q;
  assign bus.in_granted = in_granted_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_switch_allocator;
  import switch_pkg::*;

  localparam int unsigned NI = 4;
  localparam int unsigned NO = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned SW = sel_width(NI);
  localparam int unsigned OW = sel_width(NO);
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_allocator_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus ();

  switch_allocator #(
    .NUM_IN  (NI),
    .NUM_OUT (NO),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: who owns each output, and the arbitration order.
  bit m_busy [NO];
  int m_sel  [NO];
  int m_ptr  [NO];
  int m_age  [NO];
  bit m_err  [NO];
  bit m_gr   [NI];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [NI-1:0] rv,
                            input logic [NI-1:0][OW-1:0] rd, input logic [NO-1:0] ps);
    bit g_prev [NI];
    bit rel;
    bit found;
    int cand;
    g_prev = m_gr;
    for (int o = 0; o < int'(NO); o++) m_err[o] = 1'b0;
    if (r) begin
      for (int o = 0; o < int'(NO); o++) begin
        m_busy[o] = 1'b0; m_sel[o] = 0; m_ptr[o] = 0; m_age[o] = 0;
      end
      for (int i = 0; i < int'(NI); i++) m_gr[i] = 1'b0;
      return;
    end
    for (int o = 0; o < int'(NO); o++) begin
      if (m_busy[o]) begin
        rel = ps[o];
        if (!rel && TO_ON && (m_age[o] + 1 >= int'(TO))) begin
          rel = 1'b1;
          m_err[o] = 1'b1;
        end
        if (rel) begin
          m_busy[o] = 1'b0;
          m_gr[m_sel[o]] = 1'b0;
        end else begin
          m_age[o]++;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < int'(NI); k++) begin
          cand = (m_ptr[o] + k) % int'(NI);
          if (!found && rv[cand] && int'(rd[cand]) == o && !g_prev[cand]) begin
            found = 1'b1;
            m_busy[o] = 1'b1;
            m_sel[o] = cand;
            m_ptr[o] = (cand + 1) % int'(NI);
            m_age[o] = 0;
            m_gr[cand] = 1'b1;
          end
        end
      end
    end
  endtask

  // Apply inputs for one cycle, then advance the model past the edge.
  task automatic tick(input bit r, input logic [NI-1:0] rv,
                      input logic [NI-1:0][OW-1:0] rd, input logic [NO-1:0] ps);
    rst             = r;
    bus.req_valid   = rv;
    bus.req_dest    = rd;
    bus.packet_sent = ps;
    @(posedge clk);
    #1;
    model_step(r, rv, rd, ps);
  endtask

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int o = 0; o < int'(NO); o++) begin
        chk($sformatf("enable[%0d]", o), 32'(bus.enable[o]), 32'(m_busy[o]));
        chk($sformatf("sel[%0d]", o), 32'(bus.sel[o]), m_sel[o]);
        chk($sformatf("timeout_err[%0d]", o), 32'(bus.timeout_err[o]), 32'(m_err[o]));
      end
      for (int i = 0; i < int'(NI); i++) begin
        chk($sformatf("in_granted[%0d]", i), 32'(bus.in_granted[i]), 32'(m_gr[i]));
      end
    end
  end

  int rr_order [5] = '{0, 1, 2, 3, 0};
  logic [NI-1:0]         rv;
  logic [NI-1:0][OW-1:0] rd;
  logic [NO-1:0]         ps;
  bit                    r;

  initial begin
    bus.req_valid   = '0;
    bus.req_dest    = '0;
    bus.packet_sent = '0;
    tick(1'b1, '0, '0, '0);
    tick(1'b1, '0, '0, '0);
    chk_en = 1'b1;
    chk("reset.enable", 32'(bus.enable), 32'h0);
    chk("reset.in_granted", 32'(bus.in_granted), 32'h0);
    chk("reset.timeout_err", 32'(bus.timeout_err), 32'h0);

    // Reset mid-packet: out0 owned by in2.
    tick(1'b0, 4'b0100, 8'h00, '0);
    chk("midpkt.sel0", 32'(bus.sel[0]), 32'd2);
    chk("midpkt.enable", 32'(bus.enable), 32'h1);
    tick(1'b0, 4'b0100, 8'h00, '0);
    tick(1'b1, 4'b0100, 8'h00, '0);
    chk("midpkt.rst_enable", 32'(bus.enable), 32'h0);
    chk("midpkt.rst_granted", 32'(bus.in_granted), 32'h0);
    chk("midpkt.rst_sel", 32'(bus.sel), 32'h0);

    // Single grant: in1 -> out3, packet_sent four cycles after the grant.
    tick(1'b0, 4'b0010, 8'h0C, '0);
    chk("single.sel3", 32'(bus.sel[3]), 32'd1);
    chk("single.enable", 32'(bus.enable), 32'h8);
    chk("single.granted", 32'(bus.in_granted), 32'h2);
    repeat (4) tick(1'b0, 4'b0010, 8'h0C, '0);
    chk("single.hold", 32'(bus.enable), 32'h8);
    tick(1'b0, 4'b0000, 8'h0C, 4'b1000);
    chk("single.release", 32'(bus.enable), 32'h0);
    chk("single.sel_kept", 32'(bus.sel[3]), 32'd1);

    // Round robin on out0 with all four inputs persistent.
    tick(1'b1, '0, '0, '0);
    tick(1'b0, 4'b1111, 8'h00, '0);
    chk("rr.grant0", 32'(bus.sel[0]), rr_order[0]);
    for (int k = 1; k < 5; k++) begin
      tick(1'b0, 4'b1111, 8'h00, 4'b0001);
      chk($sformatf("rr.gap%0d", k), 32'(bus.enable[0]), 32'h0);
      tick(1'b0, 4'b1111, 8'h00, '0);
      chk($sformatf("rr.grant%0d", k), 32'(bus.sel[0]), rr_order[k]);
      chk($sformatf("rr.en%0d", k), 32'(bus.enable[0]), 32'h1);
    end

    // Parallel: in0->o1, in1->o0, in2->o1.
    tick(1'b1, '0, '0, '0);
    tick(1'b0, 4'b0111, 8'b00_01_00_01, '0);
    chk("par.sel1", 32'(bus.sel[1]), 32'd0);
    chk("par.sel0", 32'(bus.sel[0]), 32'd1);
    chk("par.enable", 32'(bus.enable), 32'h3);
    chk("par.granted", 32'(bus.in_granted), 32'h3);
    tick(1'b0, 4'b0111, 8'b00_01_00_01, 4'b0010);
    chk("par.rel_enable", 32'(bus.enable), 32'h1);
    chk("par.rel_granted", 32'(bus.in_granted), 32'h2);
    tick(1'b0, 4'b0110, 8'b00_01_00_01, '0);
    chk("par.regrant_sel1", 32'(bus.sel[1]), 32'd2);
    chk("par.regrant_granted", 32'(bus.in_granted), 32'h6);

    // Stray packet_sent on idle out2, then a locked requester changing dest.
    tick(1'b1, '0, '0, '0);
    tick(1'b0, '0, '0, 4'b0100);
    chk("stray.enable", 32'(bus.enable), 32'h0);
    tick(1'b0, 4'b0001, 8'h00, '0);
    repeat (5) tick(1'b0, 4'b0001, 8'h01, '0);
    chk("locked.enable", 32'(bus.enable), 32'h1);
    chk("locked.granted", 32'(bus.in_granted), 32'h1);

    // Long BUSY with no packet_sent on out2.
    tick(1'b1, '0, '0, '0);
    tick(1'b0, 4'b0001, 8'h02, '0);
    repeat (7) tick(1'b0, '0, '0, '0);
    chk("long.busy7", 32'(bus.enable), 32'h4);
    chk("long.noerr", 32'(bus.timeout_err), 32'h0);
    tick(1'b0, '0, '0, '0);
`ifdef SWITCH_ALLOC_TIMEOUT_EN
    chk("timeout.release", 32'(bus.enable), 32'h0);
    chk("timeout.err", 32'(bus.timeout_err), 32'h4);
    tick(1'b0, '0, '0, '0);
    chk("timeout.err_pulse", 32'(bus.timeout_err), 32'h0);
`else
    chk("notimeout.held", 32'(bus.enable), 32'h4);
    repeat (20) tick(1'b0, '0, '0, '0);
    chk("notimeout.held_long", 32'(bus.enable), 32'h4);
    chk("notimeout.err", 32'(bus.timeout_err), 32'h0);
`endif

    // Randomized traffic, including stray pulses and occasional resets.
    tick(1'b1, '0, '0, '0);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < int'(NI); i++) begin
        rv[i] = ($urandom_range(0, 3) != 0);
        rd[i] = OW'($urandom_range(0, NO - 1));
      end
      for (int o = 0; o < int'(NO); o++) begin
        ps[o] = ($urandom_range(0, (n < 1500) ? 3 : 9) == 0);
      end
      tick(r, rv, rd, ps);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
